// File: rtl/seg_scan_scheduler.sv
// Four-digit 7-segment scan driver with a two-requester round-robin digit write port.
module seg_scan_scheduler #(
  parameter int unsigned CLK_DIV      = 1048576,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [1:0] idx_a,
  input  logic [1:0] idx_b,
  input  logic [3:0] val_a,
  input  logic [3:0] val_b,
  output logic       gnt_a,
  output logic       gnt_b,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       tick
);

  localparam int unsigned CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       d_q [4];
  logic [3:0]       d_d [4];
  logic             prio_q, prio_d;  // 0 = A has priority, 1 = B
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             tick_q, tick_d;

  // Hex digit to segment pattern, bit0 = segment a.
  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'h0: enc = 7'h3F;  4'h1: enc = 7'h06;  4'h2: enc = 7'h5B;  4'h3: enc = 7'h4F;
      4'h4: enc = 7'h66;  4'h5: enc = 7'h6D;  4'h6: enc = 7'h7D;  4'h7: enc = 7'h07;
      4'h8: enc = 7'h7F;  4'h9: enc = 7'h6F;  4'hA: enc = 7'h77;  4'hB: enc = 7'h7C;
      4'hC: enc = 7'h39;  4'hD: enc = 7'h5E;  4'hE: enc = 7'h79;  default: enc = 7'h71;
    endcase
  endfunction

  // Grant arbitration: lone requester wins, contention resolved by priority; nothing during reset.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst) begin
      gnt_a = req_a && (!req_b || !prio_q);
      gnt_b = req_b && (!req_a ||  prio_q);
    end
  end

  // Next-state: scan timing, digit writes, priority rotation and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    ptr_d   = ptr_q;
    tick_d  = 1'b0;
    prio_d  = prio_q;
    for (int i = 0; i < 4; i++) d_d[i] = d_q[i];

    case (state_q)
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          tick_d  = 1'b1;
        end
      end
      default: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          ptr_d   = 2'(ptr_q + 2'd1);
        end
      end
    endcase

    if (gnt_a) begin
      d_d[idx_a] = val_a;
      prio_d     = 1'b1;
    end else if (gnt_b) begin
      d_d[idx_b] = val_b;
      prio_d     = 1'b0;
    end

    an_d  = (state_q == SHOW) ? 4'(4'b0001 << ptr_q) : 4'b0000;
    seg_d = (state_q == SHOW && !blank) ? enc(d_q[ptr_q]) : 7'h00;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW;
      cnt_q   <= '0;
      ptr_q   <= '0;
      prio_q  <= 1'b0;
      seg_q   <= '0;
      an_q    <= '0;
      tick_q  <= 1'b0;
      for (int i = 0; i < 4; i++) d_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      prio_q  <= prio_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
      for (int i = 0; i < 4; i++) d_q[i] <= d_d[i];
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler with CLK_DIV=4, BLANK_CYCLES=2.
module tb_seg_scan_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [1:0] idx_a, idx_b;
  logic [3:0] val_a, val_b;
  logic       gnt_a, gnt_b;
  logic       blank;
  logic [6:0] seg;
  logic [3:0] an;
  logic       tick;

  int nvec = 0;
  int nerr = 0;
  int k    = 0;  // edges since reset released

  seg_scan_scheduler #(.CLK_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b),
    .idx_a(idx_a), .idx_b(idx_b),
    .val_a(val_a), .val_b(val_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .blank(blank), .seg(seg), .an(an), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic wait_to(input int target);
    while (k < target) wait_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cycle();
    rst = 1'b0;
    k = 0;
  endtask

  task automatic drop_reqs();
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  // Expected scan pattern at k edges after reset release with all digits 0.
  task automatic chk_scan(input string tag, input logic blank_on);
    int p, dig;
    logic [3:0] ean;
    p   = (k - 1) % 6;
    dig = ((k - 1) / 6) % 4;
    ean = (p < 4) ? 4'(4'b0001 << dig) : 4'b0000;
    chk({tag, "_an"}, 32'(an), 32'(ean));
    chk({tag, "_seg"}, 32'(seg), (p < 4 && !blank_on) ? 32'h3F : 32'h00);
    chk({tag, "_tick"}, 32'(tick), (p == 3) ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst = 1'b1; blank = 1'b0;
    req_a = 1'b1; req_b = 1'b0;
    idx_a = 2'd0; idx_b = 2'd0; val_a = 4'h7; val_b = 4'h0;

    // Reset state, including a request that must be ignored.
    wait_cycle();
    wait_cycle();
    #1;
    chk("rst_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(gnt_b), 32'd0);
    chk("rst_an", 32'(an), 32'h0);
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_tick", 32'(tick), 32'd0);
    drop_reqs();

    // Free-running scan from reset with no requests.
    rst = 1'b0;
    k = 0;
    repeat (25) begin
      wait_cycle();
      chk_scan("scan", 1'b0);
    end

    // Simultaneous requests: grants alternate A, B, A starting from priority A.
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    idx_a = 2'd1; val_a = 4'h3; idx_b = 2'd1; val_b = 4'h5;
    #1;
    chk("rr0_gnt_a", 32'(gnt_a), 32'd1);
    chk("rr0_gnt_b", 32'(gnt_b), 32'd0);
    wait_cycle();
    chk("rr1_gnt_a", 32'(gnt_a), 32'd0);
    chk("rr1_gnt_b", 32'(gnt_b), 32'd1);
    wait_cycle();
    chk("rr2_gnt_a", 32'(gnt_a), 32'd1);
    chk("rr2_gnt_b", 32'(gnt_b), 32'd0);
    wait_cycle();
    drop_reqs();
    #1;
    chk("noreq_gnt_a", 32'(gnt_a), 32'd0);
    chk("noreq_gnt_b", 32'(gnt_b), 32'd0);
    wait_to(7);
    chk("d1_an", 32'(an), 32'h2);
    chk("d1_seg", 32'(seg), 32'h4F);

    // Lone requester A writes digit 2 = A.
    req_a = 1'b1; idx_a = 2'd2; val_a = 4'hA;
    #1;
    chk("lone_gnt_a", 32'(gnt_a), 32'd1);
    chk("lone_gnt_b", 32'(gnt_b), 32'd0);
    wait_cycle();
    // Priority now B: contention goes to B, which writes digit 3 = F.
    req_a = 1'b1; req_b = 1'b1;
    idx_a = 2'd3; val_a = 4'h1; idx_b = 2'd3; val_b = 4'hF;
    #1;
    chk("prB_gnt_a", 32'(gnt_a), 32'd0);
    chk("prB_gnt_b", 32'(gnt_b), 32'd1);
    wait_cycle();
    drop_reqs();
    wait_to(13);
    chk("d2_an", 32'(an), 32'h4);
    chk("d2_seg", 32'(seg), 32'h77);
    wait_to(19);
    chk("d3_an", 32'(an), 32'h8);
    chk("d3_seg", 32'(seg), 32'h71);

    // Reset in the second BLANK cycle after digit 3.
    wait_to(23);
    rst = 1'b1;
    wait_cycle();
    chk("mid_rst_an", 32'(an), 32'h0);
    chk("mid_rst_seg", 32'(seg), 32'h0);
    chk("mid_rst_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    k = 0;
    wait_cycle();
    chk("post_rst_an", 32'(an), 32'h1);
    chk("post_rst_seg", 32'(seg), 32'h3F);
    wait_to(19);
    chk("d3clr_an", 32'(an), 32'h8);
    chk("d3clr_seg", 32'(seg), 32'h3F);

    // blank held for a full scan: segments dark, timing unchanged.
    do_reset();
    blank = 1'b1;
    repeat (24) begin
      wait_cycle();
      chk_scan("blank", 1'b1);
    end
    blank = 1'b0;
    wait_cycle();
    chk_scan("unblank", 1'b0);

    // Write to the digit currently shown: new value appears one cycle after the grant edge.
    do_reset();
    wait_to(2);
    chk("wr0_seg_before", 32'(seg), 32'h3F);
    req_a = 1'b1; idx_a = 2'd0; val_a = 4'h9;
    #1;
    chk("wr0_gnt_a", 32'(gnt_a), 32'd1);
    wait_cycle();
    drop_reqs();
    chk("wr0_seg_at_grant", 32'(seg), 32'h3F);
    wait_cycle();
    chk("wr0_seg_after", 32'(seg), 32'h6F);
    chk("wr0_an_after", 32'(an), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Absolute time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_scan_scheduler.md
SEG_SCAN_SCHEDULER -- requirements
Module: seg_scan_scheduler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1048576: SHOW dwell per digit in clk cycles (>=2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16: inter-digit blanking in clk cycles (>=1).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req_a/req_b  input  1  digit-write request from requester A/B.
REQ-006 SHALL have ports idx_a/idx_b  input  2  target digit index (0-3) for A/B.
REQ-007 SHALL have ports val_a/val_b  input  4  nibble to store for A/B.
REQ-008 SHALL have ports gnt_a/gnt_b  output  1  combinational grant; the write commits at the same edge.
REQ-009 SHALL have port blank  input  1  forces seg to 0 while high; scanning continues.
REQ-010 SHALL have port seg  output  7  registered segments, active-high, seg[0]=a ... seg[6]=g.
REQ-011 SHALL have port an  output  4  registered one-hot digit enable, active-high, an[i] = digit i.
REQ-012 SHALL have port tick  output  1  registered one-cycle pulse on each SHOW->BLANK transition.

Function
REQ-013 SHALL hold four 4-bit digit registers d0-d3 and a 2-bit scan pointer ptr.
REQ-014 SHALL run FSM states SHOW and BLANK with a dwell counter cleared on every state entry.
REQ-015 SHOW SHALL last exactly CLK_DIV cycles, then go to BLANK; tick SHALL be high in the first BLANK cycle.
REQ-016 BLANK SHALL last exactly BLANK_CYCLES cycles, then go to SHOW with ptr+1, wrapping 3->0.
REQ-017 Registered outputs SHALL reflect the previous cycle's state: in SHOW, an=onehot(ptr) and seg=enc(d[ptr]); in BLANK, an=0000 and seg=0000000.
REQ-018 enc SHALL map 0-F to: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex, bit0=a).
REQ-019 When blank=1, the next seg SHALL be 0000000; an, ptr and timing SHALL be unaffected.
REQ-020 At most one grant SHALL be asserted per cycle; a lone requester SHALL be granted in the same cycle.
REQ-021 On a simultaneous request, the requester indicated by a 1-bit priority register SHALL be granted and the other SHALL see gnt=0.
REQ-022 After any grant, priority SHALL point to the non-granted requester (round-robin); with no grant it SHALL be unchanged.
REQ-023 A granted write SHALL update d[idx] at that edge; if idx==ptr in SHOW, seg SHALL show the new value one cycle later.
REQ-024 An ungranted request SHALL have no effect; the requester holds req until it sees gnt.
REQ-025 gnt_x SHALL never be high while req_x is low.

Reset
REQ-026 While rst=1 the block SHALL set d0-d3=0, ptr=0, state=SHOW, dwell counter=0, priority=A, seg=0000000, an=0000, tick=0, gnt_a=gnt_b=0.
REQ-027 In the first cycle after rst falls, the block SHALL output an=0001 and seg=3F.
REQ-028 A rst assertion mid-SHOW or mid-BLANK SHALL abort the dwell and restart from REQ-026 at the next edge; pending requests SHALL be ignored during rst.

Verification (CLK_DIV=4, BLANK_CYCLES=2)
REQ-029 The bench SHALL release reset with no requests -> an sequence 0001 x4, 0000 x2, 0010 x4, 0000 x2, 0100 ..., 1000, then back to 0001; tick once per 6 cycles; seg=3F during SHOW.
REQ-030 The bench SHALL drive req_a with idx=2, val=A, alone -> gnt_a=1 the same cycle; seg=77 whenever an=0100.
REQ-031 The bench SHALL drive req_a and req_b together for 3 cycles with idx_a=1, val_a=3, idx_b=1, val_b=5 -> gnts are A, B, A; d1 ends at 3; seg shows 4F when an=0010.
REQ-032 The bench SHALL hold blank=1 across a full scan -> seg=0000000 throughout, an still rotating with the same timing.
REQ-033 The bench SHALL assert rst for 1 cycle in the 2nd BLANK cycle after d3=F -> next outputs an=0000, seg=0; then an=0001, seg=3F; d3 reads 0.
REQ-034 The bench SHALL write idx=0, val=9 while ptr=0 in SHOW -> seg changes from 3F to 6F exactly one cycle after the grant edge.
